// File: rtl/cla_pipe_add32.sv
// ---------------------------------------------------------------------------
// cla_pipe_add32 -- two-stage pipelined 32-bit adder built from two 16-bit
// carry-lookahead slices, behind a valid/ready stream interface.
//
//   Stage 1 : low halves added by one CLA slice. The low sum and the carry
//             out of bit 15 (c16) are registered. The high operand halves
//             and the tag are registered alongside them.
//   Stage 2 : high halves added by the second slice using the registered
//             c16. The result is written to the output register.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream offers an operation
//   in_ready   block accepts the operation this cycle
//   in_a/in_b  2*HALF-bit operands
//   in_ci      carry into bit 0
//   in_tag     TAGW-bit sideband tag, returned unchanged
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_sum    (A+B+ci) mod 2^(2*HALF)
//   out_co     carry out of the top bit
//   out_ovf    signed overflow (carry into top bit XOR carry out of it)
//   out_tag    tag of this result
//
// HALF must be 16. Other values are not supported.
// ---------------------------------------------------------------------------

// One carry-lookahead slice: 4-bit groups with group generate/propagate and
// a second lookahead level across the groups. W must be a multiple of 4.
module cla_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int NG = W / 4;

  always_comb begin
    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   cg;

    // NOTE: every combinational variable gets a value on entry, so no path
    // through the block can leave one unassigned and infer a latch.
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    gg  = '0;
    gp  = '1;
    cg  = '0;
    sum = '0;
    co  = 1'b0;

    // Group generate/propagate for each 4-bit group.
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        gp[k] = gp[k] & p[4*k+j];
      end
    end

    // Second level: carry into each group, from group terms only.
    cg[0] = ci;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end

    // Carries inside each group start from that group's lookahead carry.
    for (int k = 0; k < NG; k++) begin
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[W] = cg[NG];

    sum = p ^ c[W-1:0];
    co  = c[W];
  end

endmodule

module cla_pipe_add32 #(
  parameter int HALF = 16,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*HALF-1:0] in_a,
  input  logic [2*HALF-1:0] in_b,
  input  logic              in_ci,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*HALF-1:0] out_sum,
  output logic              out_co,
  output logic              out_ovf,
  output logic [TAGW-1:0]   out_tag
);

  // Stage 1 registers.
  logic            s1_valid;
  logic [HALF-1:0] s1_lo_sum;
  logic            s1_c16;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic [TAGW-1:0] s1_tag;

  // Slice results.
  logic [HALF-1:0] lo_sum;
  logic            lo_co;
  logic [HALF-1:0] hi_sum;
  logic            hi_co;
  logic            c_top_in;

  // Handshake terms.
  logic s2_take;
  logic in_fire;
  logic s1_fire;

  cla_slice #(.W(HALF)) u_lo (
    .a   (in_a[HALF-1:0]),
    .b   (in_b[HALF-1:0]),
    .ci  (in_ci),
    .sum (lo_sum),
    .co  (lo_co)
  );

  cla_slice #(.W(HALF)) u_hi (
    .a   (s1_a_hi),
    .b   (s1_b_hi),
    .ci  (s1_c16),
    .sum (hi_sum),
    .co  (hi_co)
  );

  // Carry into the top bit, recovered from the top sum bit:
  // sum = a ^ b ^ cin, so cin = a ^ b ^ sum.
  assign c_top_in = s1_a_hi[HALF-1] ^ s1_b_hi[HALF-1] ^ hi_sum[HALF-1];

  // The output register can take a new result when empty or draining.
  assign s2_take  = !out_valid || out_ready;
  // Stage 1 can take an operation when empty or moving forward this edge.
  // This depends combinationally on out_ready only, never on in_valid.
  assign in_ready = !s1_valid || s2_take;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_valid && s2_take;

  // NOTE: all sequential state uses non-blocking assignments, so each edge
  // sees the pre-edge values of the other registers regardless of order.
  // Data registers are reset too, so outputs are clean from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo_sum <= '0;
      s1_c16    <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_tag    <= '0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s2_take);
      if (in_fire) begin
        s1_lo_sum <= lo_sum;
        s1_c16    <= lo_co;
        s1_a_hi   <= in_a[2*HALF-1:HALF];
        s1_b_hi   <= in_b[2*HALF-1:HALF];
        s1_tag    <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
    end else begin
      out_valid <= s1_fire || (out_valid && !out_ready);
      // Fields load only when a new result moves in, so they hold while
      // stalled and while idle.
      if (s1_fire) begin
        out_sum <= {hi_sum, s1_lo_sum};
        out_co  <= hi_co;
        out_ovf <= c_top_in ^ hi_co;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_add32.sv
// ---------------------------------------------------------------------------
// Testbench for cla_pipe_add32.
// A reference queue holds the expected result of every accepted operation,
// computed with plain 33-bit arithmetic. A monitor on the falling edge checks
// each presented result against the head of the queue and pops it on an
// output transfer. Directed tests add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_cla_pipe_add32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ci;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_co;
  logic        out_ovf;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit expect_lat2 = 1'b0;
  bit shown = 1'b0;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t q[$];

  cla_pipe_add32 #(.HALF(16), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic [3:0] tag, input int c);
    exp_t e;
    logic [32:0] w;
    w     = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    e.sum = w[31:0];
    e.co  = w[32];
    // Signed overflow: operands share a sign and the result's sign differs.
    e.ovf = (a[31] == b[31]) && (w[31] != a[31]);
    e.tag = tag;
    e.cyc = c;
    return e;
  endfunction

  // Monitor: inputs change just after the rising edge, so values seen on the
  // falling edge are the ones the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      shown = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("out_valid_with_nothing_in_flight", out_valid, 1'b0);
        end else begin
          e = q[0];
          check("model_sum", out_sum, e.sum);
          check("model_co",  out_co,  e.co);
          check("model_ovf", out_ovf, e.ovf);
          check("model_tag", out_tag, e.tag);
          if (!shown) begin
            if (expect_lat2) check("latency", cyc - e.cyc, 2);
            shown = 1'b1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            shown = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_ci, in_tag, cyc));
    end
  end

  // Present an operation and return just after the edge that accepts it.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [3:0] tag);
    bit go;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_ci = ci; in_tag = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      go = in_ready;
      @(posedge clk);
      #1;
      if (go) return;
    end
    check("drive_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_ci = 1'b0; in_tag = '0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) step(1);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    step(3);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_sum", out_sum, 32'h0);
    check("reset_out_tag", out_tag, 4'h0);
    rst = 1'b0;
    step(1);
    check("reset_in_ready", in_ready, 1'b1);

    // Single op: carry crosses the slice boundary through c16.
    expect_lat2 = 1'b1;
    drive(32'h0000FFFF, 32'h00000001, 1'b0, 4'd3);
    idle();
    check("single_not_yet", out_valid, 1'b0);
    step(1);
    check("single_valid", out_valid, 1'b1);
    check("single_sum", out_sum, 32'h00010000);
    check("single_co", out_co, 1'b0);
    check("single_ovf", out_ovf, 1'b0);
    check("single_tag", out_tag, 4'd3);
    step(2);
    check("single_gone", out_valid, 1'b0);

    // Wrap with carry out, then signed overflow, back to back.
    drive(32'hFFFFFFFF, 32'h00000000, 1'b1, 4'd5);
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd6);
    idle();
    check("wrap_sum", out_sum, 32'h00000000);
    check("wrap_co", out_co, 1'b1);
    check("wrap_ovf", out_ovf, 1'b0);
    step(1);
    check("ovf_sum", out_sum, 32'h80000000);
    check("ovf_co", out_co, 1'b0);
    check("ovf_ovf", out_ovf, 1'b1);
    check("ovf_tag", out_tag, 4'd6);
    step(2);

    // Streaming: 8 ops on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      check("stream_in_ready", in_ready, 1'b1);
      drive(32'h11111111 * i, 32'h01010101, 1'b0, 4'(i));
    end
    idle();
    // Last op (i=7) appears one edge after its acceptance edge.
    step(1);
    check("stream_last_sum", out_sum, 32'h78787878);
    check("stream_last_tag", out_tag, 4'd7);
    drain();
    step(1);

    // Backpressure: two accepted, then in_ready drops and output holds.
    expect_lat2 = 1'b0;
    out_ready = 1'b0;
    drive(32'h12345678, 32'h11111111, 1'b0, 4'd1);
    drive(32'hFFFF0000, 32'h00010000, 1'b0, 4'd2);
    in_valid = 1'b1;
    in_a = 32'h80000000; in_b = 32'h80000000; in_ci = 1'b0; in_tag = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold_sum", out_sum, 32'h23456789);
      check("bp_hold_tag", out_tag, 4'd1);
      step(1);
    end
    // Simultaneous drain and accept: one result leaves, one op enters.
    out_ready = 1'b1;
    #1;
    check("sim_in_ready", in_ready, 1'b1);
    step(1);
    idle();
    check("sim_next_valid", out_valid, 1'b1);
    check("sim_next_sum", out_sum, 32'h00000000);
    check("sim_next_co", out_co, 1'b1);
    check("sim_next_tag", out_tag, 4'd2);
    step(1);
    check("sim_third_sum", out_sum, 32'h00000000);
    check("sim_third_ovf", out_ovf, 1'b1);
    check("sim_third_tag", out_tag, 4'd4);
    drain();
    step(1);

    // Reset mid-flight with two operations held.
    out_ready = 1'b0;
    drive(32'h00000010, 32'h00000020, 1'b0, 4'd8);
    drive(32'h00000030, 32'h00000040, 1'b0, 4'd9);
    idle();
    check("rst_pre_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_sum", out_sum, 32'h0);
    check("rst_async_ready", in_ready, 1'b1);
    step(2);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("rst_no_stale", out_valid, 1'b0);
      step(1);
    end
    check("rst_in_ready", in_ready, 1'b1);

    // Normal operation after reset.
    expect_lat2 = 1'b1;
    drive(32'hDEADBEEF, 32'h21524111, 1'b0, 4'd10);
    idle();
    step(1);
    check("post_rst_sum", out_sum, 32'h00000000);
    check("post_rst_co", out_co, 1'b1);
    check("post_rst_tag", out_tag, 4'd10);
    drain();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_add32.md
Name: cla_pipe_add32

Overview:
- Two-stage pipelined 32-bit adder that wraps the team's 16-bit carry-lookahead slices behind a valid/ready stream interface.
- Stage 1 adds the low halves; the low-half carry is registered. Stage 2 adds the high halves using that registered carry.
- Sits between the operand-fetch stage (upstream) and the result writeback/consumer (downstream).
- Sustains one addition per clock when downstream is ready.

Parameters:
- HALF, 16, width of one CLA slice; the full operand width is 2*HALF. Only 16 is supported; other values are unsupported.
- TAGW, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  block accepts the operation this cycle.
- in_a  input  2*HALF  operand A.
- in_b  input  2*HALF  operand B.
- in_ci  input  1  carry-in to bit 0.
- in_tag  input  TAGW  sideband tag, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  2*HALF  (A+B+ci) mod 2^32.
- out_co  output  1  carry out of bit 31.
- out_ovf  output  1  signed overflow (carry into bit 31 XOR carry out of bit 31).
- out_tag  output  TAGW  tag of this result.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = 0 and out_valid = 0.
  - out_sum, out_co, out_ovf and out_tag reset to 0.
  - All internal data registers reset to 0.
  - in_ready is 1 one the first cycle after release.
- Acceptance:
  - A transfer occurs on an edge where in_valid & in_ready.
  - An output transfer occurs on an edge where out_valid & out_ready.
- Stage 1 register, loaded on input transfer:
  - lo_sum = A[15:0]+B[15:0]+ci, computed with the CLA slice.
  - c16 = carry out of the low slice.
  - A[31:16], B[31:16] and tag are captured alongside.
- Stage 2 / output register, loaded when s1_valid and stage 2 can accept:
  - hi_sum = A_hi+B_hi+c16, computed with the CLA slice.
  - out_sum = {hi_sum, lo_sum}.
  - out_co = carry out of bit 31.
  - out_ovf = c31 ^ c32.
- Flow control (no combinational path from in_valid to out_valid):
  - s2_take = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_take. This is combinational from out_ready, which is permitted.
  - s1_valid next = (in_valid & in_ready) | (s1_valid & !s2_take).
  - out_valid next = (s1_valid & s2_take) | (out_valid & !out_ready).
- Latency and throughput:
  - Exactly 2 cycles from input transfer edge to out_valid, with no stall.
  - Full throughput: back-to-back transfers every cycle while out_ready = 1.
- Stall:
  - While out_valid & !out_ready, the output holds all fields stable.
  - Stage 1 holds its contents.
  - in_ready = !s1_valid, so at most 2 operations are in flight.
- Simultaneous events:
  - With the pipeline full and out_ready = 1 in the same cycle, stage 1 advances to the output and a new input is accepted; nothing is lost or duplicated.
- Ordering: results emerge in acceptance order; out_tag identifies each result.
- Arithmetic:
  - Unsigned modular 32-bit addition.
  - out_co and out_ovf are computed together; no saturation.
- Reset mid-operation: in-flight operations are discarded, with no output after release.
- Data registers change only on their load conditions. Outputs hold while !out_valid.

Test Plan:
- Single op: A=0x0000FFFF, B=0x00000001, ci=0, tag=3 → two cycles after acceptance: out_sum=0x00010000, co=0, ovf=0, tag=3. This exercises cross-slice carry through c16.
- Wrap and carry: A=0xFFFFFFFF, B=0x00000000, ci=1 → sum=0x00000000, co=1, ovf=0. A=0x7FFFFFFF, B=1, ci=0 → sum=0x80000000, co=0, ovf=1.
- Streaming: 8 ops on consecutive cycles with out_ready=1 (A=i*0x11111111, B=0x01010101, tag=i) → 8 results on consecutive cycles in order with matching tags; in_ready never drops.
- Backpressure: hold out_ready=0 while issuing ops → in_ready drops after 2 accepted, and out_* stays stable. Release out_ready → both results drain in order, then acceptance resumes with nothing lost.
- Simultaneous drain/accept: pipeline full, out_ready=1 and in_valid=1 in the same cycle → one result leaves and one op enters; the next cycle shows the second result.
- Reset mid-flight: assert rst asynchronously with 2 ops in flight → out_valid=0 and out_sum=0 immediately. After release, no stale results appear and in_ready=1.
